operand_fetch: RTL and testbench

Operand-fetch stage sitting directly downstream of `regfile` in the in-order RISC-V core. It accepts decoded micro-ops from decode and drives the two regfile read addresses combinationally. It forwards the writeback value, because `regfile` has no write-through bypass, and registers the operands into a single valid/ready pipeline slot feeding execute. While the slot is stalled, it keeps held operands coherent with later writebacks.

---
 rtl/riscv_pkg.sv | 8 +
 rtl/operand_bypass.sv | 15 +
 rtl/operand_fetch.sv | 89 ++++++++
 tb/tb_operand_fetch.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared core constants and the opaque decoded micro-op type.
package riscv_pkg;
  localparam int REGISTER_INDEX_WIDTH = 5;
  localparam int REGISTER_COUNT = 32;
  localparam logic [REGISTER_INDEX_WIDTH-1:0] X0 = '0;
  localparam int UOP_WIDTH = 16;
  typedef logic [UOP_WIDTH-1:0] uop_t;
endpackage

// File: rtl/operand_bypass.sv
// operand_bypass: per-source operand select of x0 zero, writeback forward, or regfile data.
module operand_bypass
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [REGISTER_INDEX_WIDTH-1:0] i_rs,
  input  logic [XLEN-1:0]                 i_rf_data,
  input  logic                            i_wb_wen,
  input  logic [REGISTER_INDEX_WIDTH-1:0] i_wb_rd,
  input  logic [XLEN-1:0]                 i_wb_wdata,
  output logic [XLEN-1:0]                 o_data
);
  assign o_data = (i_rs == X0) ? '0 : (i_wb_wen && i_wb_rd == i_rs) ? i_wb_wdata : i_rf_data;
endmodule

// File: rtl/operand_fetch.sv
// operand_fetch: regfile read, writeback forwarding and a one-slot valid/ready stage to execute.
// OPERAND_FETCH_BYPASS_EN enables capture-time forwarding; otherwise a writeback hazard stalls one cycle.
module operand_fetch
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            flush,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [REGISTER_INDEX_WIDTH-1:0] in_rs1,
  input  logic [REGISTER_INDEX_WIDTH-1:0] in_rs2,
  input  logic [REGISTER_INDEX_WIDTH-1:0] in_rd,
  input  uop_t                            in_uop,
  output logic [REGISTER_INDEX_WIDTH-1:0] rf_rs1_addr,
  output logic [REGISTER_INDEX_WIDTH-1:0] rf_rs2_addr,
  input  logic [XLEN-1:0]                 rf_rs1_data,
  input  logic [XLEN-1:0]                 rf_rs2_data,
  input  logic                            wb_wen,
  input  logic [REGISTER_INDEX_WIDTH-1:0] wb_rd,
  input  logic [XLEN-1:0]                 wb_wdata,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [XLEN-1:0]                 out_rs1_data,
  output logic [XLEN-1:0]                 out_rs2_data,
  output logic [REGISTER_INDEX_WIDTH-1:0] out_rd,
  output uop_t                            out_uop
);
  logic                            r_valid;
  logic [XLEN-1:0]                 r_rs1_data, r_rs2_data;
  logic [REGISTER_INDEX_WIDTH-1:0] r_rs1, r_rs2, r_rd;
  uop_t                            r_uop;
  logic                            w_fwd_en, w_stall, w_cap, w_snoop;
  logic [XLEN-1:0]                 w_rs1_data, w_rs2_data;
`ifdef OPERAND_FETCH_BYPASS_EN
  assign w_fwd_en = wb_wen;
  assign w_stall  = 1'b0;
`else
  // Regfile has the new value one cycle later, so wait instead of forwarding.
  assign w_fwd_en = 1'b0;
  assign w_stall  = wb_wen && wb_rd != X0 && (wb_rd == in_rs1 || wb_rd == in_rs2);
`endif
  assign rf_rs1_addr  = in_rs1;
  assign rf_rs2_addr  = in_rs2;
  assign in_ready     = (!r_valid || out_ready) && !w_stall;
  assign w_cap        = in_valid && in_ready && !flush;
  assign w_snoop      = r_valid && !out_ready && wb_wen && wb_rd != X0;
  assign out_valid    = r_valid;
  assign out_rs1_data = r_rs1_data;
  assign out_rs2_data = r_rs2_data;
  assign out_rd       = r_rd;
  assign out_uop      = r_uop;
  operand_bypass #(.XLEN(XLEN)) u_byp1 (
    .i_rs(in_rs1), .i_rf_data(rf_rs1_data), .i_wb_wen(w_fwd_en),
    .i_wb_rd(wb_rd), .i_wb_wdata(wb_wdata), .o_data(w_rs1_data)
  );
  operand_bypass #(.XLEN(XLEN)) u_byp2 (
    .i_rs(in_rs2), .i_rf_data(rf_rs2_data), .i_wb_wen(w_fwd_en),
    .i_wb_rd(wb_rd), .i_wb_wdata(wb_wdata), .o_data(w_rs2_data)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid    <= 1'b0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rd       <= '0;
      r_uop      <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_cap) begin
      r_valid    <= 1'b1;
      r_rs1_data <= w_rs1_data;
      r_rs2_data <= w_rs2_data;
      r_rs1      <= in_rs1;
      r_rs2      <= in_rs2;
      r_rd       <= in_rd;
      r_uop      <= in_uop;
    end else begin
      if (out_ready) r_valid <= 1'b0;
      // Held operands track later writebacks so a long stall never hands out stale data.
      if (w_snoop && wb_rd == r_rs1) r_rs1_data <= wb_wdata;
      if (w_snoop && wb_rd == r_rs2) r_rs2_data <= wb_wdata;
    end
  end
endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: directed checks of operand_fetch against a small behavioural regfile.
module tb_operand_fetch;
  import riscv_pkg::*;
`ifdef OPERAND_FETCH_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif
  logic                            clk = 1'b0;
  logic                            rst, flush, in_valid, in_ready, wb_wen, out_valid, out_ready;
  logic [REGISTER_INDEX_WIDTH-1:0] in_rs1, in_rs2, in_rd, rf_rs1_addr, rf_rs2_addr, wb_rd, out_rd;
  uop_t                            in_uop, out_uop;
  logic [31:0]                     rf_rs1_data, rf_rs2_data, wb_wdata, out_rs1_data, out_rs2_data;
  logic [31:0]                     rf [REGISTER_COUNT];
  int                              checks = 0;
  int                              errors = 0;
  int                              n;
  always #5 clk = ~clk;
  always @(posedge clk) if (wb_wen && wb_rd != X0) rf[wb_rd] <= wb_wdata;
  assign rf_rs1_data = rf[rf_rs1_addr];
  assign rf_rs2_data = rf[rf_rs2_addr];
  operand_fetch #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_uop(in_uop),
    .rf_rs1_addr(rf_rs1_addr), .rf_rs2_addr(rf_rs2_addr),
    .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
    .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_wdata(wb_wdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
    .out_rd(out_rd), .out_uop(out_uop)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    for (int i = 0; i < REGISTER_COUNT; i++) rf[i] = '0;
    rf[1] = 32'h12345678;
    rf[2] = 32'hdeadbeef;
    rf[5] = 32'haaaa0001;
    rf[7] = 32'h00000001;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_uop = '0;
    wb_wen = 1'b0; wb_rd = '0; wb_wdata = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst_valid", {31'b0, out_valid}, 0);
    chk("rst_rs1", out_rs1_data, 0);
    chk("rst_rs2", out_rs2_data, 0);
    chk("rst_rd", {27'b0, out_rd}, 0);
    chk("rst_uop", {16'b0, out_uop}, 0);
    chk("rst_ready", {31'b0, in_ready}, 1);
    // basic fetch, then back-to-back capture while draining
    in_valid = 1'b1; in_rs1 = 5'd1; in_rs2 = 5'd2; in_rd = 5'd3; in_uop = 16'h00a5; out_ready = 1'b1;
    #1;
    chk("rf_addr1", {27'b0, rf_rs1_addr}, 1);
    chk("rf_addr2", {27'b0, rf_rs2_addr}, 2);
    tick();
    in_rs1 = 5'd2; in_rs2 = 5'd1; in_rd = 5'd9; in_uop = 16'h005a;
    #1;
    chk("basic_valid", {31'b0, out_valid}, 1);
    chk("basic_rs1", out_rs1_data, 32'h12345678);
    chk("basic_rs2", out_rs2_data, 32'hdeadbeef);
    chk("basic_rd", {27'b0, out_rd}, 3);
    chk("basic_uop", {16'b0, out_uop}, 32'h00a5);
    chk("b2b_ready", {31'b0, in_ready}, 1);
    tick();
    in_valid = 1'b0;
    #1;
    chk("b2b_valid", {31'b0, out_valid}, 1);
    chk("b2b_rs1", out_rs1_data, 32'hdeadbeef);
    chk("b2b_rs2", out_rs2_data, 32'h12345678);
    chk("b2b_rd", {27'b0, out_rd}, 9);
    tick();
    chk("drain_valid", {31'b0, out_valid}, 0);
    // same-cycle writeback to a source
    in_valid = 1'b1; in_rs1 = 5'd5; in_rs2 = 5'd0; in_rd = 5'd6;
    wb_wen = 1'b1; wb_rd = 5'd5; wb_wdata = 32'hbbbb0002;
    #1;
    chk("fwd_ready", {31'b0, in_ready}, {31'b0, BYP});
    tick();
    wb_wen = 1'b0;
`ifndef OPERAND_FETCH_BYPASS_EN
    #1;
    chk("fwd_stall_valid", {31'b0, out_valid}, 0);
    chk("fwd_retry_ready", {31'b0, in_ready}, 1);
    tick();
`endif
    in_valid = 1'b0;
    #1;
    chk("fwd_valid", {31'b0, out_valid}, 1);
    chk("fwd_rs1", out_rs1_data, 32'hbbbb0002);
    chk("fwd_rs2", out_rs2_data, 0);
    tick();
    // x0 is never forwarded and never stalls
    in_valid = 1'b1; in_rs1 = 5'd0; in_rs2 = 5'd1; in_rd = 5'd4;
    wb_wen = 1'b1; wb_rd = 5'd0; wb_wdata = 32'hffffffff;
    #1;
    chk("x0_ready", {31'b0, in_ready}, 1);
    tick();
    wb_wen = 1'b0; in_valid = 1'b0;
    #1;
    chk("x0_rs1", out_rs1_data, 0);
    chk("x0_rs2", out_rs2_data, 32'h12345678);
    tick();
    // stall with hold-snoop, then release
    out_ready = 1'b0;
    in_valid = 1'b1; in_rs1 = 5'd1; in_rs2 = 5'd7; in_rd = 5'd8;
    tick();
    in_rs1 = 5'd9; in_rs2 = 5'd10; in_rd = 5'd11;
    wb_wen = 1'b1; wb_rd = 5'd7; wb_wdata = 32'h55aa55aa;
    #1;
    chk("stall_ready0", {31'b0, in_ready}, 0);
    chk("stall_rs2_pre", out_rs2_data, 1);
    tick();
    wb_wen = 1'b0;
    #1;
    chk("snoop_rs2", out_rs2_data, 32'h55aa55aa);
    chk("snoop_rs1", out_rs1_data, 32'h12345678);
    chk("snoop_rd", {27'b0, out_rd}, 8);
    chk("stall_ready1", {31'b0, in_ready}, 0);
    tick();
    chk("hold_valid", {31'b0, out_valid}, 1);
    chk("hold_rs2", out_rs2_data, 32'h55aa55aa);
    in_valid = 1'b0; out_ready = 1'b1;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      if (out_valid && out_ready) n++;
      tick();
    end
    chk("release_xfers", n, 1);
    // flush with a competing input
    out_ready = 1'b0;
    in_valid = 1'b1; in_rs1 = 5'd1; in_rs2 = 5'd2; in_rd = 5'd12;
    tick();
    chk("preflush_valid", {31'b0, out_valid}, 1);
    flush = 1'b1; in_rs1 = 5'd2; in_rd = 5'd13;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    chk("flush_valid", {31'b0, out_valid}, 0);
    tick();
    chk("flush_nocap", {31'b0, out_valid}, 0);
    // asynchronous reset mid-stall
    in_valid = 1'b1; in_rs1 = 5'd2; in_rs2 = 5'd1; in_rd = 5'd14;
    tick();
    in_valid = 1'b0;
    #1;
    chk("prerst_valid", {31'b0, out_valid}, 1);
    rst = 1'b1;
    #1;
    chk("arst_valid", {31'b0, out_valid}, 0);
    chk("arst_rs1", out_rs1_data, 0);
    chk("arst_rd", {27'b0, out_rd}, 0);
    tick();
    rst = 1'b0;
    #1;
    chk("postrst_ready", {31'b0, in_ready}, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
